// File: rtl/spm_dp_be.sv
// Dual-port scratch-pad memory with per-port byte enables, registered reads,
// write-first same-address collisions and an out-of-range error pulse.
module spm_dp_be #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic [ADDR_W-1:0]   if_spm_addr,
  input  logic                if_spm_as_,
  input  logic                if_spm_rw,
  input  logic [DATA_W/8-1:0] if_spm_be,
  input  logic [DATA_W-1:0]   if_spm_wr_data,
  output logic [DATA_W-1:0]   if_spm_rd_data,
  output logic                if_spm_rd_valid,
  output logic                if_spm_err,
  input  logic [ADDR_W-1:0]   mem_spm_addr,
  input  logic                mem_spm_as_,
  input  logic                mem_spm_rw,
  input  logic [DATA_W/8-1:0] mem_spm_be,
  input  logic [DATA_W-1:0]   mem_spm_wr_data,
  output logic [DATA_W-1:0]   mem_spm_rd_data,
  output logic                mem_spm_rd_valid,
  output logic                mem_spm_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_if_acc, w_if_rd, w_if_wr, w_if_inr;
  logic              w_mem_acc, w_mem_rd, w_mem_wr, w_mem_inr;
  logic              w_same;
  logic [IDX_W-1:0]  w_if_idx, w_mem_idx;
  logic [DATA_W-1:0] w_if_rd_word, w_mem_rd_word;

  logic [DATA_W-1:0] r_if_rd_data_p1, r_mem_rd_data_p1;
  logic              r_if_vld_p1, r_mem_vld_p1;
  logic              r_if_err_p1, r_mem_err_p1;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int k = 0; k < BE_W; k++) begin
      if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

  assign w_if_acc  = ~if_spm_as_;
  assign w_if_rd   = w_if_acc & if_spm_rw;
  assign w_if_wr   = w_if_acc & ~if_spm_rw;
  assign w_if_inr  = ({1'b0, if_spm_addr} < LIMIT);
  assign w_if_idx  = if_spm_addr[IDX_W-1:0];

  assign w_mem_acc = ~mem_spm_as_;
  assign w_mem_rd  = w_mem_acc & mem_spm_rw;
  assign w_mem_wr  = w_mem_acc & ~mem_spm_rw;
  assign w_mem_inr = ({1'b0, mem_spm_addr} < LIMIT);
  assign w_mem_idx = mem_spm_addr[IDX_W-1:0];

  assign w_same    = (if_spm_addr == mem_spm_addr);

  // Write-first: a reader sees the other port's enabled bytes from the same edge.
  always_comb begin
    w_if_rd_word = '0;
    if (w_if_inr) begin
      if (w_mem_wr && w_same)
        w_if_rd_word = merge_bytes(r_mem[w_if_idx], mem_spm_wr_data, mem_spm_be);
      else
        w_if_rd_word = r_mem[w_if_idx];
    end
  end

  always_comb begin
    w_mem_rd_word = '0;
    if (w_mem_inr) begin
      if (w_if_wr && w_same)
        w_mem_rd_word = merge_bytes(r_mem[w_mem_idx], if_spm_wr_data, if_spm_be);
      else
        w_mem_rd_word = r_mem[w_mem_idx];
    end
  end

  // MEM bytes are assigned last so they win where both ports enable a byte.
  always_ff @(posedge clk) begin
    if (rst_) begin
      for (int k = 0; k < BE_W; k++) begin
        if (w_if_wr && w_if_inr && if_spm_be[k])
          r_mem[w_if_idx][8*k +: 8] <= if_spm_wr_data[8*k +: 8];
        if (w_mem_wr && w_mem_inr && mem_spm_be[k])
          r_mem[w_mem_idx][8*k +: 8] <= mem_spm_wr_data[8*k +: 8];
      end
    end
  end

  // Stage p1: registered read data, valid and error strobes.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_if_rd_data_p1  <= '0;
      r_if_vld_p1      <= 1'b0;
      r_if_err_p1      <= 1'b0;
      r_mem_rd_data_p1 <= '0;
      r_mem_vld_p1     <= 1'b0;
      r_mem_err_p1     <= 1'b0;
    end else begin
      r_if_vld_p1  <= w_if_rd;
      r_if_err_p1  <= w_if_acc & ~w_if_inr;
      r_mem_vld_p1 <= w_mem_rd;
      r_mem_err_p1 <= w_mem_acc & ~w_mem_inr;
      if (w_if_rd)  r_if_rd_data_p1  <= w_if_rd_word;
      if (w_mem_rd) r_mem_rd_data_p1 <= w_mem_rd_word;
    end
  end

  assign if_spm_rd_data   = r_if_rd_data_p1;
  assign if_spm_rd_valid  = r_if_vld_p1;
  assign if_spm_err       = r_if_err_p1;
  assign mem_spm_rd_data  = r_mem_rd_data_p1;
  assign mem_spm_rd_valid = r_mem_vld_p1;
  assign mem_spm_err      = r_mem_err_p1;

endmodule

// File: tb/tb_spm_dp_be.sv
// Randomised and directed bench for spm_dp_be against a word-array reference model.
module tb_spm_dp_be;

  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int DEPTH = 1024;

  logic          clk;
  logic          rst_;
  logic [AW-1:0] if_spm_addr, mem_spm_addr;
  logic          if_spm_as_, mem_spm_as_;
  logic          if_spm_rw, mem_spm_rw;
  logic [3:0]    if_spm_be, mem_spm_be;
  logic [DW-1:0] if_spm_wr_data, mem_spm_wr_data;
  logic [DW-1:0] if_spm_rd_data, mem_spm_rd_data;
  logic          if_spm_rd_valid, mem_spm_rd_valid;
  logic          if_spm_err, mem_spm_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] e_if_data, e_mem_data;
  logic          e_if_vld, e_mem_vld, e_if_err, e_mem_err;

  spm_dp_be #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_             (rst_),
    .if_spm_addr      (if_spm_addr),
    .if_spm_as_       (if_spm_as_),
    .if_spm_rw        (if_spm_rw),
    .if_spm_be        (if_spm_be),
    .if_spm_wr_data   (if_spm_wr_data),
    .if_spm_rd_data   (if_spm_rd_data),
    .if_spm_rd_valid  (if_spm_rd_valid),
    .if_spm_err       (if_spm_err),
    .mem_spm_addr     (mem_spm_addr),
    .mem_spm_as_      (mem_spm_as_),
    .mem_spm_rw       (mem_spm_rw),
    .mem_spm_be       (mem_spm_be),
    .mem_spm_wr_data  (mem_spm_wr_data),
    .mem_spm_rd_data  (mem_spm_rd_data),
    .mem_spm_rd_valid (mem_spm_rd_valid),
    .mem_spm_err      (mem_spm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_write(input logic [AW-1:0] a, input logic [3:0] be, input logic [DW-1:0] d);
    if (int'(a) < DEPTH) begin
      for (int k = 0; k < 4; k++)
        if (be[k]) model_mem[int'(a)][8*k +: 8] = d[8*k +: 8];
    end
  endtask

  // Reference: apply both writes (IF then MEM), then any read returns the updated word.
  always @(posedge clk) begin
    if (!rst_) begin
      e_if_data = '0;  e_if_vld = 1'b0;  e_if_err = 1'b0;
      e_mem_data = '0; e_mem_vld = 1'b0; e_mem_err = 1'b0;
    end else begin
      if (!if_spm_as_ && !if_spm_rw)   model_write(if_spm_addr, if_spm_be, if_spm_wr_data);
      if (!mem_spm_as_ && !mem_spm_rw) model_write(mem_spm_addr, mem_spm_be, mem_spm_wr_data);
      e_if_vld = !if_spm_as_ && if_spm_rw;
      e_if_err = !if_spm_as_ && (int'(if_spm_addr) >= DEPTH);
      if (e_if_vld) e_if_data = (int'(if_spm_addr) < DEPTH) ? model_mem[int'(if_spm_addr)] : '0;
      e_mem_vld = !mem_spm_as_ && mem_spm_rw;
      e_mem_err = !mem_spm_as_ && (int'(mem_spm_addr) >= DEPTH);
      if (e_mem_vld) e_mem_data = (int'(mem_spm_addr) < DEPTH) ? model_mem[int'(mem_spm_addr)] : '0;
    end
    #1;
    check("if_rd_data",   if_spm_rd_data,           e_if_data);
    check("if_rd_valid",  32'(if_spm_rd_valid),     32'(e_if_vld));
    check("if_err",       32'(if_spm_err),          32'(e_if_err));
    check("mem_rd_data",  mem_spm_rd_data,          e_mem_data);
    check("mem_rd_valid", 32'(mem_spm_rd_valid),    32'(e_mem_vld));
    check("mem_err",      32'(mem_spm_err),         32'(e_mem_err));
  end

  task automatic set_if(input logic as_n, input logic rw, input logic [AW-1:0] a,
                        input logic [3:0] be, input logic [DW-1:0] d);
    if_spm_as_ = as_n; if_spm_rw = rw; if_spm_addr = a; if_spm_be = be; if_spm_wr_data = d;
  endtask

  task automatic set_mem(input logic as_n, input logic rw, input logic [AW-1:0] a,
                         input logic [3:0] be, input logic [DW-1:0] d);
    mem_spm_as_ = as_n; mem_spm_rw = rw; mem_spm_addr = a; mem_spm_be = be; mem_spm_wr_data = d;
  endtask

  task automatic idle();
    set_if(1'b1, 1'b1, '0, '0, '0);
    set_mem(1'b1, 1'b1, '0, '0, '0);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, 1100));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst_ = 1'b0;
    idle();
    repeat (3) step();
    check("reset_if_data",   if_spm_rd_data,          32'h0);
    check("reset_if_vld",    32'(if_spm_rd_valid),    32'h0);
    check("reset_mem_data",  mem_spm_rd_data,         32'h0);
    check("reset_mem_err",   32'(mem_spm_err),        32'h0);
    rst_ = 1'b1;

    for (int a = 0; a < DEPTH; a += 2) begin
      set_if(1'b0, 1'b0, AW'(a), 4'hF, $urandom);
      set_mem(1'b0, 1'b0, AW'(a + 1), 4'hF, $urandom);
      step();
    end
    idle();

    for (int i = 0; i < 40; i++) begin
      set_mem(1'b0, 1'b0, AW'(i), 4'hF, 32'(i));
      step();
    end
    for (int i = 0; i < 40; i++) begin
      set_mem(1'b0, 1'b1, AW'(i), 4'h0, '0);
      step();
      check("b2b_rd_data",  mem_spm_rd_data,       32'(i));
      check("b2b_rd_valid", 32'(mem_spm_rd_valid), 32'h1);
    end

    set_mem(1'b0, 1'b0, 12'd5, 4'hF, 32'hAABBCCDD); step();
    set_mem(1'b0, 1'b0, 12'd5, 4'b0101, 32'h11223344); step();
    set_mem(1'b0, 1'b1, 12'd5, 4'h0, '0); step();
    check("be_merge", mem_spm_rd_data, 32'hAA22CC44);

    set_mem(1'b0, 1'b0, 12'd7, 4'hF, 32'h12345678); step();
    set_mem(1'b0, 1'b0, 12'd7, 4'h3, 32'h0000FFFF);
    set_if(1'b0, 1'b1, 12'd7, 4'h0, '0);
    step();
    check("rw_collision", if_spm_rd_data, 32'h1234FFFF);

    set_if(1'b0, 1'b0, 12'd9, 4'hF, 32'h11111111);
    set_mem(1'b0, 1'b0, 12'd9, 4'h1, 32'h22222222);
    step();
    set_if(1'b0, 1'b1, 12'd9, 4'h0, '0);
    set_mem(1'b1, 1'b1, '0, '0, '0);
    step();
    check("ww_collision", if_spm_rd_data, 32'h11111122);
    set_if(1'b1, 1'b1, '0, '0, '0);

    set_mem(1'b0, 1'b0, 12'd0, 4'hF, 32'hCAFEF00D); step();
    set_mem(1'b0, 1'b1, 12'h400, 4'h0, '0); step();
    check("oor_rd_data",  mem_spm_rd_data,       32'h0);
    check("oor_rd_valid", 32'(mem_spm_rd_valid), 32'h1);
    check("oor_rd_err",   32'(mem_spm_err),      32'h1);
    set_mem(1'b0, 1'b0, 12'h400, 4'hF, 32'h55555555); step();
    check("oor_wr_err",   32'(mem_spm_err),      32'h1);
    set_mem(1'b0, 1'b1, 12'd0, 4'h0, '0); step();
    check("oor_wr_noalias", mem_spm_rd_data,     32'hCAFEF00D);
    check("inr_err",      32'(mem_spm_err),      32'h0);

    set_if(1'b0, 1'b1, 12'd5, 4'h0, '0); step();
    idle();
    #2 rst_ = 1'b0;
    #1;
    check("async_rst_if_data",  if_spm_rd_data,       32'h0);
    check("async_rst_mem_data", mem_spm_rd_data,      32'h0);
    check("async_rst_if_vld",   32'(if_spm_rd_valid), 32'h0);
    check("async_rst_mem_vld",  32'(mem_spm_rd_valid),32'h0);
    step();
    rst_ = 1'b1;

    set_mem(1'b0, 1'b0, 12'd20, 4'hF, 32'hDEADBEEF);
    rst_ = 1'b0;
    step();
    check("rst_wr_vld", 32'(mem_spm_rd_valid), 32'h0);
    rst_ = 1'b1;
    set_mem(1'b0, 1'b1, 12'd20, 4'h0, '0); step();
    check("rst_wr_discard", mem_spm_rd_data, 32'd20);

    for (int c = 0; c < 3000; c++) begin
      set_if(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(),
             4'($urandom), $urandom);
      set_mem(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(),
              4'($urandom), $urandom);
      step();
    end
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
